hb_interp_x2: RTL and testbench

- 2x half-band interpolator. Each 16-bit signed input sample produces two output samples at twice the sample rate.
- It is the rate-increase counterpart to the half-band decimating filter. It sits on the transmit/upsample side of the same sample stream.
- 11-tap half-band prototype, implemented polyphase:
  - Even branch: 6-tap symmetric FIR.
  - Odd branch: pure delay (centre tap).
- Valid/ready handshake on both the input and the output side.

---
 rtl/hb_interp_x2.sv | 193 +++++++++++++++++++
 tb/tb_hb_interp_x2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hb_interp_x2.sv
`default_nettype none
// ============================================================================
//  Module      : hb_interp_x2
//  Description : 2x half-band interpolator. Each 16-bit signed input sample
//                yields an (even, odd) output pair. The even phase is a 6-tap
//                symmetric FIR (C5, C3, C1, C1, C3, C5). The odd phase is the
//                centre-tap delay x[n-2]. Valid/ready handshake on both sides.
//                Optional macro HB_INTERP_OVF_EN adds a sticky saturation
//                flag output 'ovf'.
//  Revision    : 1.0 - initial release
// ============================================================================
module hb_interp_x2 #(
    parameter logic signed [15:0] C1 = 16'sd19700,
    parameter logic signed [15:0] C3 = -16'sd3958,
    parameter logic signed [15:0] C5 = 16'sd616
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic signed [15:0] m_data,
    output logic               m_valid,
    input  logic               m_ready
`ifdef HB_INTERP_OVF_EN
    ,
    output logic               ovf
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC1 = 3'd1,
        S_MAC2 = 3'd2,
        S_EVEN = 3'd3,
        S_ODD  = 3'd4
    } state_t;

    localparam logic signed [34:0] C_ROUND = 35'sd16384;
    localparam logic signed [34:0] C_MAX   = 35'sd32767;
    localparam logic signed [34:0] C_MIN   = -35'sd32768;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_s_ready;
    logic               w_m_valid;

    logic signed [15:0] r_x [0:5];
    logic signed [32:0] r_prod1;
    logic signed [32:0] r_prod3;
    logic signed [32:0] r_prod5;
    logic signed [15:0] r_y_odd;
    logic signed [15:0] r_m_data;

    logic signed [16:0] w_p1;
    logic signed [16:0] w_p3;
    logic signed [16:0] w_p5;
    logic signed [32:0] w_m1;
    logic signed [32:0] w_m3;
    logic signed [32:0] w_m5;
    logic signed [34:0] w_sum;
    logic signed [34:0] w_shift;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic signed [15:0] w_y_even;

    // Symmetric pre-adds: taps sharing a coefficient are summed first (17 bit)
    assign w_p5 = $signed({r_x[0][15], r_x[0]}) + $signed({r_x[5][15], r_x[5]});
    assign w_p3 = $signed({r_x[1][15], r_x[1]}) + $signed({r_x[4][15], r_x[4]});
    assign w_p1 = $signed({r_x[2][15], r_x[2]}) + $signed({r_x[3][15], r_x[3]});

    // 17x16 products, operands sign-extended to the full 33-bit result width
    assign w_m5 = $signed({{16{w_p5[16]}}, w_p5}) * $signed({{17{C5[15]}}, C5});
    assign w_m3 = $signed({{16{w_p3[16]}}, w_p3}) * $signed({{17{C3[15]}}, C3});
    assign w_m1 = $signed({{16{w_p1[16]}}, w_p1}) * $signed({{17{C1[15]}}, C1});

    // Accumulate with round-half-up, then drop the Q15 fraction
    assign w_sum   = $signed({{2{r_prod1[32]}}, r_prod1})
                   + $signed({{2{r_prod3[32]}}, r_prod3})
                   + $signed({{2{r_prod5[32]}}, r_prod5})
                   + C_ROUND;
    assign w_shift = w_sum >>> 15;

    // Clamp to the 16-bit range; the output must never wrap
    assign w_sat_hi = (w_shift > C_MAX);
    assign w_sat_lo = (w_shift < C_MIN);
    assign w_y_even = w_sat_hi ? 16'sh7FFF :
                      w_sat_lo ? 16'sh8000 :
                                 w_shift[15:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_m_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_s_ready = 1'b1;
                if (s_valid) begin
                    w_state_next = S_MAC1;
                end
            end
            S_MAC1: w_state_next = S_MAC2;
            S_MAC2: w_state_next = S_EVEN;
            S_EVEN: begin
                w_m_valid = 1'b1;
                if (m_ready) begin
                    w_state_next = S_ODD;
                end
            end
            S_ODD: begin
                w_m_valid = 1'b1;
                if (m_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign s_ready = w_s_ready;
    assign m_valid = w_m_valid;
    assign m_data  = r_m_data;

    // Datapath: delay line, product registers and output staging
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                r_x[i] <= '0;
            end
            r_prod1  <= '0;
            r_prod3  <= '0;
            r_prod5  <= '0;
            r_y_odd  <= '0;
            r_m_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_valid) begin
                        for (int i = 5; i > 0; i--) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_x[0] <= s_data;
                    end
                end
                S_MAC1: begin
                    r_prod1 <= w_m1;
                    r_prod3 <= w_m3;
                    r_prod5 <= w_m5;
                end
                S_MAC2: begin
                    // Even sample is loaded straight into the output register
                    r_m_data <= w_y_even;
                    r_y_odd  <= r_x[2];
                end
                S_EVEN: begin
                    if (m_ready) begin
                        r_m_data <= r_y_odd;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HB_INTERP_OVF_EN
    logic r_ovf;

    // Sticky flag: set whenever the even result is clipped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_MAC2 && (w_sat_hi || w_sat_lo)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    // No overflow flag in this build; saturation still applies
`endif

endmodule
`default_nettype wire

// File: tb/tb_hb_interp_x2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hb_interp_x2
//  Description : Self-checking bench for hb_interp_x2. Directed impulse, DC,
//                saturation, backpressure, timing and reset cases plus random
//                samples compared against a dot-product reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hb_interp_x2;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_ready;
`ifdef HB_INTERP_OVF_EN
    logic               ovf;
`endif

    hb_interp_x2 dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef HB_INTERP_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    // Reference: newest input first, hist[k] = x[n-k]
    longint hist [6];
    longint coef [6] = '{616, -3958, 19700, 19700, -3958, 616};

    function automatic longint ref_even();
        longint acc = 0;
        for (int k = 0; k < 6; k++) acc += coef[k] * hist[k];
        acc = (acc + 16384) >>> 15;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) hist[k] = 0;
    endtask

    // One sample through the block; stall = cycles of m_ready=0 in EVEN
    task automatic send(input logic signed [15:0] v, input int stall,
                        output logic signed [15:0] ev, output logic signed [15:0] od);
        int n = 0;
        s_data  = v;
        s_valid = 1'b1;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", s_ready, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v;
        @(negedge clk);
        chk("mv_mac1", m_valid, 0);
        @(negedge clk);
        chk("mv_mac2", m_valid, 0);
        m_ready = (stall == 0);
        @(negedge clk);
        chk("mv_even_latency", m_valid, 1);
        ev = m_data;
        for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            chk("bp_mvalid", m_valid, 1);
            chk("bp_hold", m_data, ev);
            chk("bp_sready", s_ready, 0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("mv_odd", m_valid, 1);
        od = m_data;
        @(negedge clk);
        chk("mv_idle", m_valid, 0);
        chk("sready_idle", s_ready, 1);
        chk("even_model", ev, ref_even());
        chk("odd_model", od, hist[2]);
    endtask

    logic signed [15:0] ev, od;
    logic signed [15:0] imp_e [8] = '{308, -1979, 9850, 9850, -1979, 308, 0, 0};
    logic signed [15:0] imp_o [8] = '{0, 0, 16384, 0, 0, 0, 0, 0};
    logic signed [15:0] sat_in [6] = '{-32768, 32767, -32768, -32768, 32767, -32768};
    logic               rdy_log [30];
    logic               mv_log  [30];
    int                 last_acc;
    int                 n_rdy;

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        do_reset();
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_sready", s_ready, 1);
`ifdef HB_INTERP_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif

        // Impulse, with 4 cycles of backpressure on the first even sample
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 16'sd16384 : 16'sd0, (i == 0) ? 4 : 0, ev, od);
            chk($sformatf("imp_even%0d", i), ev, imp_e[i]);
            chk($sformatf("imp_odd%0d", i), od, imp_o[i]);
        end

        // DC full scale
        for (int i = 0; i < 10; i++) begin
            send(16'sd32767, 0, ev, od);
            if (i >= 5) begin
                chk("dc_even", ev, 32715);
                chk("dc_odd", od, 32767);
            end
        end
`ifdef HB_INTERP_OVF_EN
        chk("dc_ovf", ovf, 0);
`endif

        // Saturation
        do_reset();
        for (int i = 0; i < 6; i++) send(16'sd0, 0, ev, od);
        for (int i = 0; i < 6; i++) send(sat_in[i], 0, ev, od);
        chk("sat_even", ev, -32768);
        chk("sat_odd", od, -32768);
        for (int i = 0; i < 3; i++) send(16'sd0, 0, ev, od);
`ifdef HB_INTERP_OVF_EN
        chk("sat_ovf_sticky", ovf, 1);
`endif

        // Timing with s_valid held high
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_data = 16'($urandom);
            rdy_log[i] = s_ready;
            mv_log[i]  = m_valid;
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_rdy = 0;
        last_acc = -1;
        for (int i = 0; i < 30; i++) begin
            if (rdy_log[i]) begin
                n_rdy++;
                if (last_acc >= 0) chk("tim_period", i - last_acc, 5);
                last_acc = i;
                if (i + 3 < 30) begin
                    chk("tim_mv_pre", mv_log[i+2], 0);
                    chk("tim_mv_rise", mv_log[i+3], 1);
                end
            end
        end
        chk("tim_count", n_rdy, 6);

        // Reset during MAC2
        do_reset();
        s_data  = 16'sd16384;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) hist[k] = 0;
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_out", m_valid, 0);
            @(negedge clk);
        end
        send(16'sd0, 0, ev, od);
        chk("midrst_even", ev, 0);
        chk("midrst_odd", od, 0);

        // Random samples with random backpressure
        for (int i = 0; i < 24; i++) begin
            int sel = $urandom_range(0, 3);
            logic signed [15:0] v;
            v = (sel == 0) ? 16'sd32767 : (sel == 1) ? -16'sd32768 : 16'($urandom);
            send(v, $urandom_range(0, 3), ev, od);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
